// File: rtl/axil_cmd_pkg.sv
// axil_cmd_pkg: state encoding and AXI response codes shared by axil_cmd_master
package axil_cmd_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_e;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single valid/ready commands into AXI4-Lite reads/writes, one at a time
// Ports: cmd_* command in (valid/ready), rsp_* result out (valid/ready, timeout flag),
//        aw/w/b and ar/r AXI4-Lite master channels; clk, rst_n (async active-low).
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_e state_q;
  logic wr_q, aw_done_q, w_done_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic aw_hs, w_hs, x_hs, expired;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign x_hs    = (bvalid && bready) || (rvalid && rready);
  assign cnt_d   = cnt_q + 1'b1;
  // A handshake in the same cycle takes priority over expiry (checked first below).
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_d == CW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= OKAY;
      rsp_timeout <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      wvalid      <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      rready      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            wr_q      <= cmd_write;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr    <= cmd_addr;
            araddr    <= cmd_addr;
            wdata     <= cmd_wdata;
            wstrb     <= cmd_wstrb;
            awvalid   <= cmd_write;
            wvalid    <= cmd_write;
            arvalid   <= !cmd_write;
            state_q   <= cmd_write ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid   <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready  <= 1'b1;
            cnt_q   <= '0;
            state_q <= WR_RESP;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt_q   <= '0;
            state_q <= RD_RESP;
          end
        end
        WR_RESP, RD_RESP: begin
          if (x_hs) begin
            rsp_rdata   <= wr_q ? '0 : rdata;
            rsp_resp    <= wr_q ? bresp : rresp;
            rsp_timeout <= 1'b0;
          end else if (expired) begin
            rsp_rdata   <= '0;
            rsp_resp    <= SLVERR;
            rsp_timeout <= 1'b1;
          end
          if (x_hs || expired) begin
            bready    <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= RSP;
          end else cnt_q <= cnt_d;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // After a timeout the slave still owes one B/R beat; swallow it before going idle.
            bready    <= rsp_timeout && wr_q;
            rready    <= rsp_timeout && !wr_q;
            cmd_ready <= !rsp_timeout;
            state_q   <= rsp_timeout ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (x_hs) begin
            bready    <= 1'b0;
            rready    <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed and randomized transactions against a memory-backed AXI-Lite slave and command-level model
module tb_axil_cmd_master;
  localparam int AW = 32, DW = 32, TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata = '0;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp = '0, rresp = '0;
  int checks = 0, errors = 0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  always #5 clk = ~clk;
  axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] sget(input logic [31:0] k);
    return smem.exists(k) ? smem[k] : 32'h0;
  endfunction
  function automatic logic [31:0] mget(input logic [31:0] k);
    return mmem.exists(k) ? mmem[k] : 32'h0;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[i*8 +: 8] = d[i*8 +: 8];
    return o;
  endfunction
  // One command end to end. rq_d: request-ready delay, w_d: W-ready delay, x_d: ready cycles before B/R valid
  // (>= TO means the slave misses the deadline), late: cycles after the timeout before the late beat appears.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int rq_d, input int w_d, input int x_d, input logic [1:0] rr,
                     input int hold, input int late, output int lat);
    int n = 0, awc = 0, wc = 0, arc = 0, rc = 0, hc = 0, lc = 0;
    bit aw_ok = 0, w_ok = 0, ar_ok = 0, x_ok = 0, timed = 0, rsp_hs = 0, late_ok = 0, wrote = 0;
    bit rdone, p1, xr_exp, rsp_on, xv, done = 0;
    logic [31:0] sa = '0, sd = '0, exp_rd;
    logic [3:0] ss = '0;
    lat = -1;
    exp_rd = mget(a);
    if (wr) mmem[a] = merge(mget(a), d, s);
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1'b1);
    {awready, wready, arready, bvalid, rvalid, rsp_ready} = '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      rdone  = wr ? (aw_ok && w_ok) : ar_ok;
      p1     = rdone && !x_ok && !timed;
      xr_exp = p1 || (timed && rsp_hs && !late_ok);
      rsp_on = (x_ok || timed) && !rsp_hs;
      check("cmd_ready_busy", cmd_ready, 1'b0);
      check("rsp_valid", rsp_valid, rsp_on);
      check("awvalid", awvalid, wr && !aw_ok);
      check("wvalid", wvalid, wr && !w_ok);
      check("arvalid", arvalid, !wr && !ar_ok);
      check("bready", bready, wr && xr_exp);
      check("rready", rready, !wr && xr_exp);
      awready = awc >= rq_d;
      wready  = wc >= w_d;
      arready = arc >= rq_d;
      if (awvalid) awc++;
      if (wvalid) wc++;
      if (arvalid) arc++;
      if (awvalid && awready) begin
        aw_ok = 1; sa = awaddr;
        check("awaddr", awaddr, a);
        check("awprot", awprot, 3'b000);
      end
      if (wvalid && wready) begin
        w_ok = 1; sd = wdata; ss = wstrb;
        check("wdata", wdata, d);
        check("wstrb", wstrb, s);
      end
      if (arvalid && arready) begin
        ar_ok = 1; sa = araddr;
        check("araddr", araddr, a);
        check("arprot", arprot, 3'b000);
      end
      if (wr && aw_ok && w_ok && !wrote) begin
        smem[sa] = merge(sget(sa), sd, ss);
        wrote = 1;
      end
      xv     = (p1 && rc >= x_d) || (timed && lc >= late && !late_ok);
      bvalid = wr && xv;
      rvalid = !wr && xv;
      bresp  = timed ? 2'($urandom) : rr;
      rresp  = timed ? 2'($urandom) : rr;
      rdata  = timed ? $urandom : sget(sa);
      if (p1) begin
        if (xv && (wr ? bready : rready)) x_ok = 1;
        else if (rc + 1 == TO) timed = 1;
        rc++;
      end else if (timed) begin
        if (xv && (wr ? bready : rready)) late_ok = 1;
        lc++;
      end
      rsp_ready = rsp_on && hc >= hold;
      if (rsp_on) begin
        check("rsp_rdata", rsp_rdata, (wr || timed) ? 32'h0 : exp_rd);
        check("rsp_resp", rsp_resp, timed ? 2'b10 : rr);
        check("rsp_timeout", rsp_timeout, timed);
        if (lat < 0) lat = n;
        if (rsp_ready) rsp_hs = 1;
        hc++;
      end
      done = timed ? late_ok : rsp_hs;
    end
    check("txn_done", done, 1'b1);
    @(negedge clk);
    {cmd_valid, awready, wready, arready, bvalid, rvalid, rsp_ready} = '0;
    check("cmd_ready_after", cmd_ready, 1'b1);
    check("quiet_after", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [31:0] ra;
    #12;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    check("rst_addr", {awaddr, araddr}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 0, lat);
    check("wr_latency", lat, 3);
    txn(1, 32'h14, 32'hCAFEF00D, 4'h5, 0, 5, 1, 2'b01, 0, 0, lat);
    check("wr_slow_w_latency", lat, 9);
    smem[32'h24] = 32'h12345678;
    mmem[32'h24] = 32'h12345678;
    txn(0, 32'h24, 32'h0, 4'h0, 0, 0, 4, 2'b11, 0, 0, lat);
    check("rd_latency", lat, 7);
    txn(0, 32'h24, 32'h0, 4'h0, 0, 0, 100, 2'b00, 0, 3, lat);
    check("rd_timeout_latency", lat, 2 + TO);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 2'b00, 10, 0, lat);
    check("rd_hold_latency", lat, 3);
    txn(0, 32'h14, 32'h0, 4'h0, 1, 0, TO - 1, 2'b01, 0, 0, lat);
    check("rd_tie_latency", lat, 3 + TO);
    txn(1, 32'h18, 32'h0BADF00D, 4'hC, 2, 0, TO, 2'b00, 1, 0, lat);
    for (int i = 0; i < 24; i++) begin
      ra = 32'($urandom_range(0, 7)) * 4;
      txn(1'($urandom), ra, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 9), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), lat);
    end
    @(negedge clk);
    check("rst2_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst2_wr_req", {awvalid, wvalid}, 2'b11);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_async_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    check("rst2_async_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_cmd_ready", cmd_ready, 1'b1);
    check("rst2_quiet", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 0, lat);
    check("rst2_rd_latency", lat, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
